// File: rtl/mm_result_writer_pkg.sv
// Shared widths, FSM state encoding and FIFO entry layout for the result writer.
package mm_result_writer_pkg;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);
endpackage

// File: rtl/mm_result_writer_result_fifo.sv
// Small synchronous FIFO holding {addr, data} result entries; head is read from
// registered storage and forced to zero while empty.
module result_fifo
  import mm_result_writer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty gating on o_head hides its stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/mm_result_writer.sv
// Captures dot-product results, tags them with row-major addresses, buffers them
// and writes them out through a ready/valid port; pulses done after the last write.
module mm_result_writer
  import mm_result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        m1_rows_m1,
  input  logic [1:0]        m2_cols_m1,
  input  logic              acc_valid,
  input  logic [DATA_W-1:0] acc_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   result_cnt
);
  localparam int CNT_W = ADDR_W + 1;

  state_t            r_state;
  logic [1:0]        r_cols_m1;
  logic [1:0]        r_row;
  logic [1:0]        r_col;
  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_push_cnt;
  logic [CNT_W-1:0]  r_result_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W-1:0] w_addr;
  fifo_entry_t       w_push_entry;
  fifo_entry_t       w_head;

  assign w_addr       = ADDR_W'(r_row) * (ADDR_W'(r_cols_m1) + ADDR_W'(1)) + ADDR_W'(r_col);
  assign w_push_entry = '{addr: w_addr, data: acc_data};
  assign w_push       = (r_state == RUN) && acc_valid;
  assign w_pop        = !w_fifo_empty && wr_ready;
  assign w_clear      = (r_state == IDLE) && start;

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign wr_en      = !w_fifo_empty;
  assign wr_addr    = w_head.addr;
  assign wr_data    = w_head.data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign result_cnt = r_result_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cols_m1    <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_total      <= '0;
      r_push_cnt   <= '0;
      r_result_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) r_result_cnt <= r_result_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cols_m1    <= m2_cols_m1;
            r_total      <= (CNT_W'(m1_rows_m1) + CNT_W'(1)) * (CNT_W'(m2_cols_m1) + CNT_W'(1));
            r_row        <= '0;
            r_col        <= '0;
            r_push_cnt   <= '0;
            r_result_cnt <= '0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (acc_valid) begin
            // Dropped words still consume their address slot.
            if (w_fifo_full && !w_pop) r_overflow <= 1'b1;
            if (r_col == r_cols_m1) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            r_push_cnt <= r_push_cnt + 1'b1;
            if (r_push_cnt + 1'b1 == r_total) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && (r_result_cnt + 1'b1 == r_total)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_result_writer.sv
// Directed bench for mm_result_writer: inputs driven and outputs sampled on the falling edge.
module tb_mm_result_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  m1_rows_m1;
  logic [1:0]  m2_cols_m1;
  logic        acc_valid;
  logic [19:0] acc_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [19:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  result_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_data [16];

  always #5 clk = ~clk;

  mm_result_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m1_rows_m1(m1_rows_m1),
    .m2_cols_m1(m2_cols_m1),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .result_cnt(result_cnt)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m1_rows_m1 = '0; m2_cols_m1 = '0;
    acc_valid = 1'b0; acc_data = '0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, overflow, result_cnt} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b done=%b ovf=%b cnt=%0d want all zero",
               wr_en, wr_addr, wr_data, busy, done, overflow, result_cnt);
    end
    rst = 1'b0;
    acc_valid = 1'b1; acc_data = 20'h12345;
    @(negedge clk);
    acc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_acc_ignored: got wr_en=%b busy=%b want 0 0", wr_en, busy);
    end
  endtask

  // Runs a full matrix with wr_ready high and results fed every cycle from exp_data.
  task automatic run_matrix(input logic [1:0] rows_m1, input logic [1:0] cols_m1, input string name);
    int n;
    n = (int'(rows_m1) + 1) * (int'(cols_m1) + 1);
    @(negedge clk);
    start = 1'b1; m1_rows_m1 = rows_m1; m2_cols_m1 = cols_m1; wr_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy step%0d: got %b want 1", name, i, busy);
      end
      if (i == 0) begin
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("FAIL %s first_wr_en: got %b want 0", name, wr_en);
        end
      end else begin
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'(i - 1), exp_data[i-1]}) begin
          errors++;
          $display("FAIL %s write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                   name, i - 1, wr_en, wr_addr, wr_data, i - 1, exp_data[i-1]);
        end
      end
      acc_valid = (i < n);
      acc_data  = (i < n) ? exp_data[i] : 20'd0;
    end
    @(negedge clk);
    checks++;
    if ({done, busy, wr_en, overflow, result_cnt} !== {4'b1000, 5'(n)}) begin
      errors++;
      $display("FAIL %s completion: got done=%b busy=%b wr_en=%b ovf=%b cnt=%0d want 1 0 0 0 %0d",
               name, done, busy, wr_en, overflow, result_cnt, n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: got %b want 0", name, done);
    end
  endtask

  task automatic test_basic_2x3();
    exp_data[0] = 20'd10;
    exp_data[1] = -20'sd5;
    exp_data[2] = 20'd7;
    exp_data[3] = 20'd0;
    exp_data[4] = 20'sd524287;
    exp_data[5] = -20'sd524288;
    run_matrix(2'd1, 2'd2, "basic_2x3");
  endtask

  task automatic test_back_to_back_4x4();
    for (int i = 0; i < 16; i++) exp_data[i] = 20'(i * 4099 - 30000);
    run_matrix(2'd3, 2'd3, "stream_4x4");
  endtask

  task automatic test_stall_1x1();
    @(negedge clk);
    start = 1'b1; m1_rows_m1 = 2'd0; m2_cols_m1 = 2'd0; wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; acc_valid = 1'b1; acc_data = -20'sd123;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc_valid = 1'b0; acc_data = 20'd0;
      checks++;
      if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'd0, -20'sd123, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold%0d: got en=%b addr=%0d data=%h busy=%b want en=1 addr=0 data=%h busy=1",
                 i, wr_en, wr_addr, wr_data, busy, -20'sd123);
      end
    end
    wr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, busy, wr_en, result_cnt} !== {3'b100, 5'd1}) begin
      errors++;
      $display("FAIL stall_done: got done=%b busy=%b wr_en=%b cnt=%0d want 1 0 0 1",
               done, busy, wr_en, result_cnt);
    end
  endtask

  task automatic test_overflow_2x2();
    @(negedge clk);
    start = 1'b1; m1_rows_m1 = 2'd1; m2_cols_m1 = 2'd1; wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; acc_valid = 1'b1; acc_data = 20'(11 * (i + 1));
    end
    @(negedge clk);
    acc_valid = 1'b0; acc_data = 20'd0;
    checks++;
    if ({overflow, busy, wr_en, wr_addr, wr_data} !== {3'b111, 4'd0, 20'd11}) begin
      errors++;
      $display("FAIL ovf_flag_head: got ovf=%b busy=%b en=%b addr=%0d data=%0d want 1 1 1 0 11",
               overflow, busy, wr_en, wr_addr, wr_data);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd1, 20'd22}) begin
      errors++;
      $display("FAIL ovf_second_write: got en=%b addr=%0d data=%0d want 1 1 22", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    start = 1'b1; m1_rows_m1 = 2'd0; m2_cols_m1 = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, busy, done, overflow, result_cnt} !== {4'b0101, 5'd2}) begin
      errors++;
      $display("FAIL ovf_stuck_drain: got en=%b busy=%b done=%b ovf=%b cnt=%0d want 0 1 0 1 2",
               wr_en, busy, done, overflow, result_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, overflow, result_cnt} !== 7'd0) begin
      errors++;
      $display("FAIL ovf_reset_clear: got busy=%b ovf=%b cnt=%0d want 0 0 0", busy, overflow, result_cnt);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; m1_rows_m1 = 2'd1; m2_cols_m1 = 2'd1; wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; acc_valid = 1'b1; acc_data = 20'd5;
    @(negedge clk);
    acc_data = 20'd6;
    @(negedge clk);
    acc_valid = 1'b0; acc_data = 20'd0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, overflow, result_cnt} !== 33'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got en=%b addr=%0d data=%h busy=%b done=%b ovf=%b cnt=%0d want all zero",
               wr_en, wr_addr, wr_data, busy, done, overflow, result_cnt);
    end
    for (int i = 0; i < 4; i++) exp_data[i] = 20'(100 + i);
    run_matrix(2'd1, 2'd1, "after_reset_2x2");
  endtask

  initial begin
    test_reset();
    test_basic_2x3();
    test_back_to_back_4x4();
    test_stall_1x1();
    test_overflow_2x2();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
